instr_history_reader: RTL
=========================

Name: instr_history_reader

Overview:
- Read-side companion to the writeback-stage instruction backup chain.
- Captures every retired instruction (IR and PC) from the W stage into a circular history buffer.
- Freezes the buffer when an exception or interrupt is taken, so the pre-exception history is preserved.
- Lets the CP0/debug side read entry k (k retirements back) through a request/valid handshake.

Parameters:
- AW, 3, index width; history depth is DEPTH = 2**AW entries (8).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  an instruction retires in W this cycle.
- wr_ir  in  32  retiring instruction word (IR_W).
- wr_pc  in  32  retiring PC (PC_W).
- freeze  in  1  pulse: exception/interrupt taken; stop capturing.
- clear  in  1  pulse (eret or debug): empty the buffer and unfreeze.
- rd_req  in  1  read request.
- rd_idx  in  AW  entry to read; 0 = most recent retirement.
- rd_valid  out  1  read response strobe.
- rd_hit  out  1  requested entry exists (rd_idx < count at request time).
- rd_ir  out  32  IR of the entry; 0 on miss.
- rd_pc  out  32  PC of the entry; 0 on miss.
- count  out  AW+1  valid entries, saturating at DEPTH.
- frozen  out  1  capture disabled.
- overrun  out  1  sticky: a write was dropped while frozen.

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: wptr=0, count=0, frozen=0, overrun=0, rd_valid=0, rd_hit=0, rd_ir=0, rd_pc=0. Memory contents are don't-care; they are never visible because reads gate on count.
- Write (wr_en && !frozen):
  - mem[wptr] <= {wr_pc, wr_ir}.
  - wptr <= wptr+1, wrapping mod DEPTH.
  - count <= min(count+1, DEPTH).
  - Once full, each new write overwrites the oldest entry.
- Write while frozen (wr_en && frozen): no memory, pointer or count change; overrun <= 1.
- Freeze:
  - freeze=1 sets frozen at the next edge.
  - A wr_en in the same cycle as freeze is still captured; the freeze takes effect from the following cycle.
- Clear:
  - clear=1 at the next edge: wptr=0, count=0, frozen=0, overrun=0.
  - A wr_en in the same cycle as clear is discarded.
  - clear and freeze together: clear is applied, then frozen=1, i.e. the buffer is empty and frozen.
- Read, fixed 1-cycle latency:
  - rd_req sampled at edge N; rd_valid=1 for exactly one cycle after edge N.
  - Entry address = (wptr - 1 - rd_idx) mod DEPTH, using the wptr value before edge N.
  - rd_hit = (rd_idx < count) using the count before edge N.
  - On a miss, rd_ir and rd_pc are 0.
  - A write and a read in the same cycle: the read returns the pre-write view. Index 0 is the previous retirement, not the one being written.
- Back-to-back reads: one request is accepted per cycle with no stall. rd_ir/rd_pc hold their value until the next rd_valid.
- rd_valid with rd_req=0 is 0 on the next cycle.
- Reset asserted mid-read: rd_valid drops immediately (asynchronous); the pending response is lost.
- Reads are allowed in any state, frozen or not. Reads never change state.

Decomposition:
- Shared package: AW default, DEPTH derivation, entry width constant (64 = PC+IR), field offsets (PC high, IR low).
- One natural sub-module: hist_ram. It is DEPTH x 64 with one synchronous write port and one registered read port, and no reset on contents.
- Pointer, count, freeze/overrun control and hit logic stay in the top module.

Test Plan:
- Reset, then rd_req idx=0 -> next cycle rd_valid=1, rd_hit=0, rd_ir=0, rd_pc=0; count=0.
- Retire IR 0x11,0x22,0x33 at PC 0x3000,0x3004,0x3008, then read idx 0,1,2 back-to-back -> rd_ir 0x33,0x22,0x11 with matching PCs on consecutive cycles; count=3; idx=3 -> rd_hit=0.
- Retire 10 instructions 0x01..0x0A (DEPTH=8) -> count=8; idx=0 -> 0x0A; idx=7 -> 0x03.
- Retire 0x40 in the freeze cycle, then 0x41 while frozen -> idx=0 returns 0x40, overrun=1, frozen=1. Pulse clear -> count=0, frozen=0, overrun=0.
- wr_en 0x55 and rd_req idx=0 in the same cycle, previous retirement 0x54 -> response 0x54. The next read of idx=0 -> 0x55.
- Assert reset asynchronously between rd_req and its response -> rd_valid stays 0 and count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_history_reader_pkg.sv
// Shared constants and types for the retired-instruction history reader.
package instr_history_reader_pkg;

    // Default index width; history depth is 2**HIST_AW entries.
    localparam int HIST_AW    = 3;
    localparam int HIST_DEPTH = 2 ** HIST_AW;

    // Each entry holds the retiring PC in the upper half and the IR in the lower half.
    localparam int FIELD_W = 32;
    localparam int ENTRY_W = 2 * FIELD_W;
    localparam int IR_LSB  = 0;
    localparam int PC_LSB  = FIELD_W;

    typedef struct packed {
        logic [FIELD_W-1:0] pc;
        logic [FIELD_W-1:0] ir;
    } hist_entry_t;

    // Builds a stored entry from the W-stage PC and IR.
    function automatic hist_entry_t pack_entry(input logic [FIELD_W-1:0] pc,
                                               input logic [FIELD_W-1:0] ir);
        hist_entry_t e;
        e.pc = pc;
        e.ir = ir;
        return e;
    endfunction

endpackage

// File: rtl/instr_history_reader_hist_ram.sv
// History storage: 2**AW x W, one synchronous write port, one registered read port.
module instr_history_reader_hist_ram
    import instr_history_reader_pkg::*;
#(
    parameter int AW = HIST_AW,
    parameter int W  = ENTRY_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rdata_q;

    // Capture the retiring entry at the write address.
    // NOTE: storage carries no reset; the top only exposes entries that the count says were written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds the last word until the next request, and sees pre-write contents.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_history_reader.sv
// Captures retired instructions into a circular history, freezes on exceptions,
// and serves k-back reads with a fixed one-cycle latency.
module instr_history_reader
    import instr_history_reader_pkg::*;
#(
    parameter int AW = HIST_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [31:0]   wr_ir,
    input  logic [31:0]   wr_pc,
    input  logic          freeze,
    input  logic          clear,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_idx,
    output logic          rd_valid,
    output logic          rd_hit,
    output logic [31:0]   rd_ir,
    output logic [31:0]   rd_pc,
    output logic [AW:0]   count,
    output logic          frozen,
    output logic          overrun
);

    localparam int DEPTH = 2 ** AW;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;
    logic          frozen_q, frozen_d;
    logic          overrun_q, overrun_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_hit_q, rd_hit_d;

    logic          ram_we;
    logic [AW-1:0] rd_addr;
    hist_entry_t   rd_entry;

    // Next-state for pointer, occupancy, freeze/overrun and read response.
    // NOTE: every signal gets a default first so no path leaves a value unassigned (no latches).
    always_comb begin
        wptr_d     = wptr_q;
        count_d    = count_q;
        frozen_d   = frozen_q;
        overrun_d  = overrun_q;
        ram_we     = 1'b0;
        rd_valid_d = rd_req;
        rd_hit_d   = rd_hit_q;
        rd_addr    = wptr_q - AW'(1) - rd_idx;

        if (clear) begin
            // Clear discards a same-cycle write; a same-cycle freeze leaves it empty and frozen.
            wptr_d    = '0;
            count_d   = '0;
            overrun_d = 1'b0;
            frozen_d  = freeze;
        end else begin
            if (wr_en && !frozen_q) begin
                ram_we = 1'b1;
                wptr_d = wptr_q + AW'(1);
                if (count_q != (AW+1)'(DEPTH)) begin
                    count_d = count_q + (AW+1)'(1);
                end
            end else if (wr_en) begin
                overrun_d = 1'b1;
            end
            if (freeze) begin
                frozen_d = 1'b1;
            end
        end

        // Hit uses the pre-edge count, so a same-cycle write is not yet visible.
        if (rd_req) begin
            rd_hit_d = ({1'b0, rd_idx} < count_q);
        end
    end

    // State registers with asynchronous active-high reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            count_q    <= '0;
            frozen_q   <= 1'b0;
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            frozen_q   <= frozen_d;
            overrun_q  <= overrun_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
        end
    end

    instr_history_reader_hist_ram #(
        .AW (AW),
        .W  (ENTRY_W)
    ) u_hist_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata (pack_entry(wr_pc, wr_ir)),
        .re    (rd_req),
        .raddr (rd_addr),
        .rdata (rd_entry)
    );

    // A miss returns zeros; both the hit flag and RAM word hold until the next request.
    assign rd_ir    = rd_hit_q ? rd_entry.ir : 32'h0;
    assign rd_pc    = rd_hit_q ? rd_entry.pc : 32'h0;
    assign rd_valid = rd_valid_q;
    assign rd_hit   = rd_hit_q;
    assign count    = count_q;
    assign frozen   = frozen_q;
    assign overrun  = overrun_q;

endmodule
